// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, keeps at most one I-memory request in flight
// and hands instructions to decode through a registered output backed by a 1-entry skid.
module fetch_sequencer #(
   parameter int unsigned       ADDR_W  = 32,
   parameter int unsigned       DATA_W  = 32,
   parameter logic [ADDR_W-1:0] BOOT_PC = ADDR_W'(32'h0000_1000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              b_taken,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_instr
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              kill_q, kill_d;
   logic              if_valid_q, if_valid_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic [DATA_W-1:0] if_instr_q, if_instr_d;
   logic              skid_valid_q, skid_valid_d;
   logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic [DATA_W-1:0] skid_instr_q, skid_instr_d;

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] redir_pc;

   assign pc_inc   = pc_q + ADDR_W'(4);
   assign redir_pc = b_addr & WORD_MASK;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_d       = kill_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;

      if (if_valid_q && !stall) begin
         if_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (mem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
               end else if (!if_valid_q || !stall) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pc_q;
                  if_instr_d = mem_rsp_data;
                  pc_d       = pc_inc;
                  state_d    = ST_REQ;
               end else begin
                  skid_valid_d = 1'b1;
                  skid_pc_d    = pc_q;
                  skid_instr_d = mem_rsp_data;
                  pc_d         = pc_inc;
                  state_d      = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (!stall) begin
               if_valid_d   = skid_valid_q;
               if_pc_d      = skid_pc_q;
               if_instr_d   = skid_instr_q;
               skid_valid_d = 1'b0;
               state_d      = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Redirect overrides everything above, including stall; a request accepted in the
      // same cycle is already on the wrong path, so its response must be discarded.
      if (b_taken && (state_q != ST_IDLE)) begin
         pc_d         = redir_pc;
         if_valid_d   = 1'b0;
         skid_valid_d = 1'b0;
         case (state_q)
            ST_REQ: begin
               kill_d  = mem_req_ready;
               state_d = mem_req_ready ? ST_WAIT : ST_REQ;
            end
            ST_WAIT: begin
               kill_d  = !mem_rsp_valid;
               state_d = mem_rsp_valid ? ST_REQ : ST_WAIT;
            end
            default: begin
               kill_d  = 1'b0;
               state_d = ST_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= BOOT_PC & WORD_MASK;
         kill_q       <= 1'b0;
         skid_valid_q <= 1'b0;
         if_valid_q   <= 1'b0;
         if_pc_q      <= '0;
         if_instr_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         kill_q       <= kill_d;
         skid_valid_q <= skid_valid_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
      end
   end

   // Skid payload is only meaningful while skid_valid_q is set, so it needs no reset.
   always_ff @(posedge clk) begin
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
   end

   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_req_addr  = pc_q;
   assign if_valid      = if_valid_q;
   assign if_pc         = if_pc_q;
   assign if_instr      = if_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: random memory latency, stalls and redirects, with an
// expected in-order PC stream checked by a negedge monitor.
module tb_fetch_sequencer;
   localparam logic [31:0] BOOT = 32'h0000_1000;

   logic        clk;
   logic        rst;
   logic        stall, b_taken;
   logic [31:0] b_addr;
   logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
   logic [31:0] mem_req_addr, mem_rsp_data;
   logic        if_valid;
   logic [31:0] if_pc, if_instr;

   logic        w_req_valid, w_rsp_valid, w_if_valid;
   logic [31:0] w_req_addr, w_rsp_data, w_if_pc, w_if_instr;

   int          vectors = 0;
   int          miscompares = 0;
   int          n_deliv = 0;
   logic [31:0] exp_q[$];
   logic [31:0] gen_pc;

   bit          rnd_ready, rnd_stall, rnd_redir, stall_cmd;
   bit          redir_in_wait, redir_on_rsp;
   logic [31:0] dir_addr;
   int          min_delay, max_delay;
   bit          pend, acc_seen;
   int          dly;
   logic [31:0] pend_addr, acc_addr;

   bit          w_acc;
   int          w_cnt = 0;
   logic [31:0] w_addr0, w_addr1;
   int          w_dcnt = 0;
   logic [31:0] w_dpc, w_dinstr;

   fetch_sequencer u_dut (
      .clk(clk), .rst(rst), .stall(stall), .b_taken(b_taken), .b_addr(b_addr),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
   );

   fetch_sequencer #(.BOOT_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .stall(1'b0), .b_taken(1'b0), .b_addr(32'h0),
      .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr), .mem_req_ready(1'b1),
      .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
      .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(gen_pc);
         gen_pc = gen_pc + 32'd4;
      end
   endtask

   task automatic reset_sb(input logic [31:0] start);
      exp_q.delete();
      gen_pc = start & 32'hFFFF_FFFC;
      refill();
   endtask

   // One clock of stimulus: memory responder, ready, stall and redirect.
   task automatic cycle();
      bit dir;
      @(posedge clk);
      #1;
      if (acc_seen) begin
         chk("one_outstanding", 32'(pend), 32'd0);
         pend      = 1'b1;
         pend_addr = acc_addr;
         dly       = $urandom_range(max_delay, min_delay);
         acc_seen  = 1'b0;
      end
      mem_rsp_valid = 1'b0;
      if (pend) begin
         if (dly == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = imem(pend_addr);
            pend          = 1'b0;
         end else begin
            dly--;
         end
      end
      mem_req_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd_stall) stall = ($urandom_range(0, 2) == 0);
      else           stall = stall_cmd;
      b_taken = 1'b0;
      dir     = 1'b0;
      if (rst) begin
         if (redir_on_rsp && mem_rsp_valid) begin
            b_taken = 1'b1; dir = 1'b1; redir_on_rsp = 1'b0;
         end else if (redir_in_wait && pend) begin
            b_taken = 1'b1; dir = 1'b1; redir_in_wait = 1'b0;
         end else if (rnd_redir && ($urandom_range(0, 15) == 0)) begin
            b_taken = 1'b1;
         end
      end
      if (b_taken) begin
         if (dir)                             b_addr = dir_addr;
         else if ($urandom_range(0, 7) == 0)  b_addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else                                 b_addr = $urandom;
         reset_sb(b_addr);
      end
      refill();
   endtask

   // Monitor: protocol rules and in-order delivery against the expected PC stream.
   initial begin
      bit          p_ok, p_ifv, p_stall, p_bt, p_rv, p_rdy;
      logic [31:0] p_pc, p_instr, p_raddr, e;
      p_ok = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (mem_req_valid && mem_req_ready) begin
               acc_seen = 1'b1;
               acc_addr = mem_req_addr;
               chk("req_align", 32'(mem_req_addr[1:0]), 32'd0);
            end
            if (p_ok && p_ifv && p_stall && !p_bt) begin
               chk("stall_hold_valid", 32'(if_valid), 32'd1);
               chk("stall_hold_pc", if_pc, p_pc);
               chk("stall_hold_instr", if_instr, p_instr);
            end
            if (p_ok && p_rv && !p_rdy && !p_bt) begin
               chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
               chk("req_hold_addr", mem_req_addr, p_raddr);
            end
            if (if_valid && !stall && !b_taken) begin
               n_deliv++;
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL deliv_underflow: got pc %h with nothing expected", if_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("deliv_pc", if_pc, e);
                  chk("deliv_instr", if_instr, imem(e));
               end
            end
            p_ok = 1'b1; p_ifv = if_valid; p_stall = stall; p_bt = b_taken;
            p_pc = if_pc; p_instr = if_instr;
            p_rv = mem_req_valid; p_rdy = mem_req_ready; p_raddr = mem_req_addr;
         end else begin
            p_ok = 1'b0;
         end
      end
   end

   // Zero-wait responder and capture for the wrap-around instance.
   initial begin
      w_rsp_valid = 1'b0;
      w_rsp_data  = 32'h0000_0013;
      w_acc       = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         w_rsp_valid = w_acc;
         w_acc       = 1'b0;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst && w_req_valid) begin
            w_acc = 1'b1;
            if (w_cnt == 0) w_addr0 = w_req_addr;
            if (w_cnt == 1) w_addr1 = w_req_addr;
            w_cnt++;
         end
         if (rst && w_if_valid) begin
            if (w_dcnt == 0) begin
               w_dpc    = w_if_pc;
               w_dinstr = w_if_instr;
            end
            w_dcnt++;
         end
      end
   end

   initial begin
      int  lat;
      bit  got;
      rst = 1'b1; stall = 1'b0; b_taken = 1'b0; b_addr = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      rnd_ready = 1'b0; rnd_stall = 1'b0; rnd_redir = 1'b0; stall_cmd = 1'b0;
      redir_in_wait = 1'b0; redir_on_rsp = 1'b0; dir_addr = '0;
      min_delay = 0; max_delay = 0; pend = 1'b0; acc_seen = 1'b0; dly = 0;
      reset_sb(BOOT);
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_valid", 32'(mem_req_valid), 32'd0);
      chk("reset_if_valid", 32'(if_valid), 32'd0);
      chk("reset_if_pc", if_pc, 32'd0);
      chk("reset_if_instr", if_instr, 32'd0);

      // Zero-wait memory: first delivery three edges after release, then one every two.
      @(posedge clk);
      #2 rst = 1'b1;
      reset_sb(BOOT);
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         cycle();
         @(negedge clk);
         lat++;
         if (if_valid) got = 1'b1;
      end
      chk("first_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 4; i++) begin
         cycle();
         @(negedge clk);
      end
      #1 chk("sustained_count", 32'(n_deliv), 32'd3);

      // Stall for five cycles while an instruction is presented.
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         cycle();
         if (if_valid) got = 1'b1;
      end
      chk("stall_setup", 32'(got), 32'd1);
      stall_cmd = 1'b1;
      stall     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) cycle();
         @(negedge clk);
         if (i >= 2) chk("hold_no_req", 32'(mem_req_valid), 32'd0);
      end
      stall_cmd = 1'b0;
      repeat (8) cycle();

      // Redirect in WAIT before the response arrives.
      min_delay = 2; max_delay = 2;
      dir_addr = 32'h0000_2002;
      redir_in_wait = 1'b1;
      for (int i = 0; i < 20 && redir_in_wait; i++) cycle();
      chk("redir_wait_issued", 32'(redir_in_wait), 32'd0);
      repeat (10) cycle();

      // Redirect in the same cycle as the response.
      min_delay = 0; max_delay = 1;
      redir_on_rsp = 1'b1;
      for (int i = 0; i < 20 && redir_on_rsp; i++) cycle();
      chk("redir_rsp_issued", 32'(redir_on_rsp), 32'd0);
      repeat (10) cycle();

      // Reset asserted while a response is still outstanding.
      min_delay = 3; max_delay = 3;
      for (int i = 0; i < 20 && !pend; i++) cycle();
      chk("midwait_setup", 32'(pend), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("midrst_if_valid", 32'(if_valid), 32'd0);
      chk("midrst_if_pc", if_pc, 32'd0);
      chk("midrst_if_instr", if_instr, 32'd0);
      dly = 1;
      cycle();
      #2 rst = 1'b1;
      reset_sb(BOOT);
      min_delay = 0; max_delay = 0;
      repeat (12) cycle();

      // Randomized traffic.
      rnd_ready = 1'b1; rnd_stall = 1'b1; rnd_redir = 1'b1;
      min_delay = 0; max_delay = 3;
      repeat (3000) cycle();
      rnd_stall = 1'b0; rnd_redir = 1'b0; stall_cmd = 1'b0;
      repeat (30) cycle();
      @(negedge clk);
      #1;
      chk("deliveries_min", 32'(n_deliv > 200), 32'd1);
      chk("wrap_first_addr", w_addr0, 32'hFFFF_FFFC);
      chk("wrap_second_addr", w_addr1, 32'h0000_0000);
      chk("wrap_first_pc", w_dpc, 32'hFFFF_FFFC);
      chk("wrap_first_instr", w_dinstr, 32'h0000_0013);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
